lfsr_keystream_xor: RTL and testbench
=====================================

Name: lfsr_keystream_xor

Overview:
- Downstream consumer and controller of the 80-bit `lfsr` block.
- Drives the LFSR's `Par_load`/`shift_en`, loads the seed and discards a warm-up run of keystream bits.
- Then encrypts a byte stream: for each accepted input byte it collects 8 serial keystream bits from the LFSR's `Ser_out` and XORs them with the byte.
- Input and output use valid/ready handshakes; sits between the LFSR and the byte-level datapath.

Parameters:
- DATA_W, 8, byte width and number of keystream bits gathered per byte.
- SEED_W, 80, seed width passed through to the LFSR.
- WARMUP, 16, keystream bits discarded after seed load (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse: load seed and begin warm-up; honoured only in IDLE.
- seed  in  SEED_W  key/IV value, sampled on the start edge.
- data_in  in  DATA_W  plaintext byte.
- data_valid  in  1  data_in is valid.
- data_ready  out  1  unit can accept a byte (high only in WAIT_DATA).
- cipher_out  out  DATA_W  encrypted byte, held stable while cipher_valid=1.
- cipher_valid  out  1  cipher_out is valid.
- cipher_ready  in  1  downstream accepts cipher_out.
- lfsr_par_load  out  1  to LFSR `Par_load`.
- lfsr_shift_en  out  1  to LFSR `shift_en`.
- lfsr_seed  out  SEED_W  to LFSR `Seed`; registered copy of seed.
- lfsr_ser_in  in  1  from LFSR `Ser_out`.
- busy  out  1  high in any state except IDLE.
- byte_count  out  16  number of bytes completed since last load; wraps 0xFFFF→0.

Behaviour:
- Reset (synchronous, every edge with rst=1):
  - State goes to IDLE.
  - All outputs are 0: cipher_out, cipher_valid, data_ready, lfsr_par_load, lfsr_shift_en, lfsr_seed, busy, byte_count.
  - The bit counter and the partial keystream byte are cleared.
  - rst mid-operation abandons the byte in flight; no cipher_valid is produced for it.
- Keystream sampling rule: on every edge where lfsr_shift_en=1, lfsr_ser_in is sampled before the LFSR shifts on that same edge. The first sampled bit is the LFSR output immediately after load.
- FSM states and transitions:
  - IDLE: on start=1, register seed into lfsr_seed and go to LOAD. start is ignored in every other state.
  - LOAD: exactly 1 cycle, lfsr_par_load=1. Then go to WARMUP and clear byte_count.
  - WARMUP: lfsr_shift_en=1 for exactly WARMUP cycles; sampled bits are discarded. Then go to WAIT_DATA.
  - WAIT_DATA: data_ready=1 and lfsr_shift_en=0. On an edge with data_valid=1, latch data_in and go to GATHER.
  - GATHER: lfsr_shift_en=1 for exactly DATA_W cycles. Bits are shifted into the keystream register MSB-first (first sampled bit → bit DATA_W-1).
    - On the DATA_W-th sampling edge: cipher_out <= latched data XOR completed keystream (last bit included); cipher_valid <= 1; byte_count increments; go to OUT.
  - OUT: hold cipher_out and cipher_valid. lfsr_shift_en=0 and data_ready=0 (no new byte accepted while output is pending). On an edge with cipher_ready=1, clear cipher_valid and go to WAIT_DATA.
- Latency: accept edge → cipher_valid high is exactly DATA_W cycles. Minimum byte-to-byte period with cipher_ready held high is DATA_W+2 cycles.
- LFSR control exclusivity: lfsr_par_load and lfsr_shift_en are never both 1. The LFSR never shifts outside WARMUP and GATHER, so keystream bits are never skipped or reused.
- Back-pressure: cipher_ready=0 holds OUT indefinitely; cipher_out must not change.
- Data stability: data_in changes after the accept edge do not affect the result.
- Width rules: XOR is bitwise at DATA_W. The bit counter is sized ceil(log2(max(WARMUP, DATA_W)+1)).

Test Plan:
- Reset and idle: rst=1 for 2 cycles with start/data_valid toggling → all outputs 0, state IDLE, busy=0. A start pulse during rst is ignored.
- Load and warm-up: seed=80'habcdef012345abcdef67, start pulse, WARMUP=16 → lfsr_par_load high exactly 1 cycle; lfsr_shift_en high exactly 16 consecutive cycles; data_ready rises the next cycle; lfsr_seed = seed.
- Constant keystream: bench ties lfsr_ser_in=1, data_in=8'h5A → cipher_out=8'hA5 exactly 8 cycles after the accept edge; byte_count=1.
- MSB-first order: lfsr_ser_in driven 1,0,1,1,0,0,0,1 on the 8 GATHER edges, data_in=8'h00 → cipher_out=8'hB1. Also verify ser_in is sampled on shift edges only.
- Back-pressure and streaming: 3 bytes 8'h00/8'hFF/8'h3C with ser_in=0, cipher_ready low for 5 cycles on byte 2 → outputs 8'h00, 8'hFF, 8'h3C in order. cipher_out stays stable while stalled; data_ready=0 and lfsr_shift_en=0 during the stall.
- Reset mid-GATHER: assert rst after 4 of 8 shift cycles → next cycle is IDLE with all outputs 0 and no cipher_valid. A new start reloads the seed and byte_count restarts at 0.

Source files
------------

// File: rtl/lfsr_keystream_xor.sv
// lfsr_keystream_xor: controller and consumer for an external 80-bit LFSR.
// Loads the seed, discards a warm-up run of keystream bits, then XORs each
// accepted byte with the next DATA_W serial keystream bits (MSB-first).
module lfsr_keystream_xor #(
    parameter int DATA_W = 8,
    parameter int SEED_W = 80,
    parameter int WARMUP = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SEED_W-1:0] seed,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic [DATA_W-1:0] cipher_out,
    output logic              cipher_valid,
    input  logic              cipher_ready,
    output logic              lfsr_par_load,
    output logic              lfsr_shift_en,
    output logic [SEED_W-1:0] lfsr_seed,
    input  logic              lfsr_ser_in,
    output logic              busy,
    output logic [15:0]       byte_count
);

    localparam int MAX_CNT = (WARMUP > DATA_W) ? WARMUP : DATA_W;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] WARM_LAST   = CNT_W'(WARMUP - 1);
    localparam logic [CNT_W-1:0] GATHER_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WARMUP,
        S_WAIT_DATA,
        S_GATHER,
        S_OUT
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] ks_reg;
    logic [DATA_W-1:0] ks_next;
    logic [DATA_W-1:0] data_lat;
    logic              warm_done;
    logic              gather_done;

    // The bit sampled on a shift edge is the LFSR output before that shift,
    // so the completed keystream already includes the current ser_in bit.
    assign ks_next     = {ks_reg[DATA_W-2:0], lfsr_ser_in};
    assign warm_done   = (state == S_WARMUP) && (bit_cnt == WARM_LAST);
    assign gather_done = (state == S_GATHER) && (bit_cnt == GATHER_LAST);

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state and LFSR/handshake control decoded from the current state.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would infer a latch.
        state_next    = state;
        data_ready    = 1'b0;
        lfsr_par_load = 1'b0;
        lfsr_shift_en = 1'b0;
        busy          = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_next = S_LOAD;
            end
            S_LOAD: begin
                lfsr_par_load = 1'b1;
                state_next    = S_WARMUP;
            end
            S_WARMUP: begin
                lfsr_shift_en = 1'b1;
                if (warm_done) state_next = S_WAIT_DATA;
            end
            S_WAIT_DATA: begin
                data_ready = 1'b1;
                if (data_valid) state_next = S_GATHER;
            end
            S_GATHER: begin
                lfsr_shift_en = 1'b1;
                if (gather_done) state_next = S_OUT;
            end
            S_OUT: begin
                if (cipher_ready) state_next = S_WAIT_DATA;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: seed capture, bit counting, keystream gathering and output.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_seed    <= '0;
            bit_cnt      <= '0;
            ks_reg       <= '0;
            data_lat     <= '0;
            cipher_out   <= '0;
            cipher_valid <= 1'b0;
            byte_count   <= '0;
        end else begin
            if (state == S_IDLE && start) lfsr_seed <= seed;

            if (state == S_LOAD) begin
                byte_count <= '0;
                bit_cnt    <= '0;
            end

            // One count per shift edge; restart at the end of each run.
            if (lfsr_shift_en) begin
                if (warm_done || gather_done) bit_cnt <= '0;
                else                          bit_cnt <= bit_cnt + CNT_W'(1);
            end

            if (state == S_GATHER) ks_reg <= ks_next;

            if (state == S_WAIT_DATA && data_valid) data_lat <= data_in;

            if (gather_done) begin
                cipher_out   <= data_lat ^ ks_next;
                cipher_valid <= 1'b1;
                byte_count   <= byte_count + 16'd1;
            end

            if (state == S_OUT && cipher_ready) cipher_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lfsr_keystream_xor.sv
// Scoreboard bench for lfsr_keystream_xor: the stimulus pushes hand-computed
// cipher bytes into a queue, a monitor pops them on each output handshake.
module tb_lfsr_keystream_xor;

    localparam int DATA_W = 8;
    localparam int SEED_W = 80;
    localparam int WARMUP = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [SEED_W-1:0] seed = '0;
    logic [DATA_W-1:0] data_in = '0;
    logic              data_valid = 1'b0;
    logic              data_ready;
    logic [DATA_W-1:0] cipher_out;
    logic              cipher_valid;
    logic              cipher_ready = 1'b1;
    logic              lfsr_par_load;
    logic              lfsr_shift_en;
    logic [SEED_W-1:0] lfsr_seed;
    logic              lfsr_ser_in = 1'b0;
    logic              busy;
    logic [15:0]       byte_count;

    int total = 0;
    int bad   = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] mon_exp;

    lfsr_keystream_xor #(
        .DATA_W(DATA_W),
        .SEED_W(SEED_W),
        .WARMUP(WARMUP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .seed         (seed),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .cipher_out   (cipher_out),
        .cipher_valid (cipher_valid),
        .cipher_ready (cipher_ready),
        .lfsr_par_load(lfsr_par_load),
        .lfsr_shift_en(lfsr_shift_en),
        .lfsr_seed    (lfsr_seed),
        .lfsr_ser_in  (lfsr_ser_in),
        .busy         (busy),
        .byte_count   (byte_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [SEED_W-1:0] act,
                         input logic [SEED_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every accepted output byte against the scoreboard.
    always @(negedge clk) begin
        if (rst === 1'b0 && cipher_valid === 1'b1 && cipher_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_cipher", 80'(cipher_out), 80'hdead);
            end else begin
                mon_exp = exp_q.pop_front();
                check("cipher_out", 80'(cipher_out), 80'(mon_exp));
            end
        end
    end

    task automatic wait_ready(input string name);
        int n = 0;
        while (data_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check(name, 80'(data_ready), 80'd1);
    endtask

    // Load a seed and walk the warm-up, counting control pulses.
    task automatic load_seed(input logic [SEED_W-1:0] s);
        int steps = 0;
        int n_shift = 0;
        int n_par = 0;
        seed  = s;
        start = 1'b1;
        step();
        start = 1'b0;
        seed  = '0;
        check("load_par_load", 80'(lfsr_par_load), 80'd1);
        check("load_shift_off", 80'(lfsr_shift_en), 80'd0);
        check("load_seed_reg", lfsr_seed, s);
        check("load_busy", 80'(busy), 80'd1);
        while (data_ready !== 1'b1 && steps < 60) begin
            step();
            steps++;
            n_shift += int'(lfsr_shift_en);
            n_par   += int'(lfsr_par_load);
        end
        check("warm_shift_cycles", 80'(n_shift), 80'(WARMUP));
        check("warm_extra_par_load", 80'(n_par), 80'd0);
        check("warm_to_ready", 80'(steps), 80'(WARMUP + 1));
        check("count_after_load", 80'(byte_count), 80'd0);
    endtask

    // One byte: ks holds the keystream bits in the order they are presented.
    task automatic run_byte(input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] ks,
                            input logic [DATA_W-1:0] exp, input int stall);
        wait_ready("data_ready_wait");
        data_in     = d;
        data_valid  = 1'b1;
        lfsr_ser_in = ~ks[DATA_W-1];
        exp_q.push_back(exp);
        step();
        data_valid = 1'b0;
        data_in    = ~d;
        for (int b = DATA_W - 1; b >= 0; b--) begin
            lfsr_ser_in = ks[b];
            if (b == 0) check("valid_early", 80'(cipher_valid), 80'd0);
            step();
        end
        lfsr_ser_in = ~ks[0];
        check("latency_valid", 80'(cipher_valid), 80'd1);
        if (stall > 0) begin
            cipher_ready = 1'b0;
            for (int s = 0; s < stall; s++) begin
                step();
                check("stall_out_stable", 80'(cipher_out), 80'(exp));
                check("stall_ready_low", 80'({data_ready, lfsr_shift_en}), 80'd0);
                check("stall_valid_held", 80'(cipher_valid), 80'd1);
            end
            cipher_ready = 1'b1;
        end
        step();
        check("valid_cleared", 80'(cipher_valid), 80'd0);
    endtask

    initial begin
        // Reset with start/data_valid toggling; start must not load the seed.
        seed       = 80'habcdef012345abcdef67;
        rst        = 1'b1;
        start      = 1'b1;
        data_valid = 1'b1;
        step();
        start      = 1'b0;
        data_valid = 1'b0;
        step();
        check("rst_outputs", 80'({cipher_valid, data_ready, lfsr_par_load,
                                  lfsr_shift_en, busy}), 80'd0);
        check("rst_cipher_out", 80'(cipher_out), 80'd0);
        check("rst_seed", lfsr_seed, 80'd0);
        check("rst_count", 80'(byte_count), 80'd0);
        rst = 1'b0;
        step();
        check("idle_after_rst", 80'(busy), 80'd0);
        check("idle_seed_unloaded", lfsr_seed, 80'd0);

        load_seed(80'habcdef012345abcdef67);

        // Constant keystream of ones inverts the byte.
        run_byte(8'h5A, 8'hFF, 8'hA5, 0);
        check("count_one", 80'(byte_count), 80'd1);

        // Bits 1,0,1,1,0,0,0,1 land MSB-first.
        run_byte(8'h00, 8'hB1, 8'hB1, 0);
        check("count_two", 80'(byte_count), 80'd2);

        // Streaming with a 5-cycle stall on the second byte.
        run_byte(8'h00, 8'h00, 8'h00, 0);
        run_byte(8'hFF, 8'h00, 8'hFF, 5);
        run_byte(8'h3C, 8'h00, 8'h3C, 0);
        check("count_five", 80'(byte_count), 80'd5);

        // Reset after 4 of 8 gather cycles abandons the byte.
        wait_ready("data_ready_mid");
        data_in     = 8'h11;
        data_valid  = 1'b1;
        lfsr_ser_in = 1'b1;
        step();
        data_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_outputs", 80'({cipher_valid, data_ready, lfsr_par_load,
                                     lfsr_shift_en, busy}), 80'd0);
        check("midrst_cipher_out", 80'(cipher_out), 80'd0);
        check("midrst_seed", lfsr_seed, 80'd0);
        check("midrst_count", 80'(byte_count), 80'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("midrst_quiet", 80'({cipher_valid, busy}), 80'd0);
        end

        load_seed(80'h0123456789abcdef0011);
        run_byte(8'h77, 8'h00, 8'h77, 0);
        check("count_restart", 80'(byte_count), 80'd1);

        step();
        step();
        check("scoreboard_empty", 80'(exp_q.size()), 80'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
